// File: rtl/nn_mem_pkg.sv
// Shared constants and arbiter FSM encoding for the NN memory subsystem.
package nn_mem_pkg;

  localparam int unsigned NN_ADDR_LEN  = 20;
  localparam int unsigned NN_DATA_LEN  = 1;
  localparam int unsigned NN_SEL_LEN   = 2;
  localparam int unsigned NN_BURST_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/nn_mem_arbiter_if.sv
// Two-client memory arbitration bus: client request ports plus the shared memory port.
interface nn_mem_arbiter_if
  import nn_mem_pkg::*;
#(
  parameter int unsigned ADDR_LEN = NN_ADDR_LEN,
  parameter int unsigned DATA_LEN = NN_DATA_LEN,
  parameter int unsigned SEL_LEN  = NN_SEL_LEN
);
  logic                req0, req1;
  logic                we0, we1;
  logic [ADDR_LEN-1:0] addr0, addr1;
  logic [SEL_LEN-1:0]  sel0, sel1;
  logic [DATA_LEN-1:0] wdata0, wdata1;
  logic                gnt0, gnt1;
  logic                rvalid0, rvalid1;
  logic [DATA_LEN-1:0] rdata;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [SEL_LEN-1:0]  mem_sel;
  logic                mem_we;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [DATA_LEN-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, sel0, sel1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_sel, mem_we, mem_wdata
  );

  // Clients and memory side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, sel0, sel1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_sel, mem_we, mem_wdata
  );

endinterface

// File: rtl/nn_mem_arbiter.sv
// Two-port memory arbiter (host loader / compute engine), round-robin with burst limit.
// Define NN_ARB_FIXED_PRIO_EN for strict port-0 priority instead.
module nn_mem_arbiter
  import nn_mem_pkg::*;
#(
  parameter int unsigned ADDR_LEN  = NN_ADDR_LEN,
  parameter int unsigned DATA_LEN  = NN_DATA_LEN,
  parameter int unsigned SEL_LEN   = NN_SEL_LEN,
  parameter int unsigned MAX_BURST = 16
) (
  input logic            clk,
  input logic            rst,
  nn_mem_arbiter_if.slave bus
);

  localparam logic [NN_BURST_LEN-1:0] BURST_LAST = NN_BURST_LEN'(MAX_BURST - 1);

  arb_state_t              r_state, w_next;
  logic [NN_BURST_LEN-1:0] r_burst_cnt;
  logic                    r_rvalid0, r_rvalid1;
  logic                    w_xfer0, w_xfer1;
  logic                    w_burst_end;
  arb_state_t              w_idle_pick;
  logic [ADDR_LEN-1:0]     w_mem_addr;
  logic [SEL_LEN-1:0]      w_mem_sel;
  logic [DATA_LEN-1:0]     w_mem_wdata;
  logic                    w_mem_we;

  assign w_xfer0     = bus.req0 && (r_state == OWN0);
  assign w_xfer1     = bus.req1 && (r_state == OWN1);
  assign w_burst_end = (r_burst_cnt == BURST_LAST);

`ifdef NN_ARB_FIXED_PRIO_EN
  assign w_idle_pick = OWN0;
`else
  logic r_rr_ptr;
  assign w_idle_pick = r_rr_ptr ? OWN1 : OWN0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) w_next = w_idle_pick;
        else if (bus.req0)        w_next = OWN0;
        else if (bus.req1)        w_next = OWN1;
      end
      OWN0: begin
        if (!bus.req0) w_next = bus.req1 ? OWN1 : IDLE;
`ifndef NN_ARB_FIXED_PRIO_EN
        else if (bus.req1 && w_burst_end) w_next = OWN1;
`endif
      end
      OWN1: begin
        if (!bus.req1) w_next = bus.req0 ? OWN0 : IDLE;
`ifdef NN_ARB_FIXED_PRIO_EN
        // port 1 only holds the memory while port 0 is silent
        else if (bus.req0) w_next = OWN0;
`else
        else if (bus.req0 && w_burst_end) w_next = OWN0;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_sel   = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    case (r_state)
      OWN0: begin
        w_mem_addr  = bus.addr0;
        w_mem_sel   = bus.sel0;
        w_mem_wdata = bus.wdata0;
        w_mem_we    = bus.we0 && bus.req0;
      end
      OWN1: begin
        w_mem_addr  = bus.addr1;
        w_mem_sel   = bus.sel1;
        w_mem_wdata = bus.wdata1;
        w_mem_we    = bus.we1 && bus.req1;
      end
      default: ;
    endcase
  end

  assign bus.gnt0      = (r_state == OWN0);
  assign bus.gnt1      = (r_state == OWN1);
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_sel   = w_mem_sel;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rvalid0 <= w_xfer0 && !bus.we0;
      r_rvalid1 <= w_xfer1 && !bus.we1;
      if (w_next != r_state)
        r_burst_cnt <= '0;
      else if ((w_xfer0 || w_xfer1) && (r_burst_cnt != '1))
        r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

`ifndef NN_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_rr_ptr <= 1'b0;
    else if ((r_state == OWN0) && (w_next != OWN0))
      r_rr_ptr <= 1'b1;
    else if ((r_state == OWN1) && (w_next != OWN1))
      r_rr_ptr <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Scoreboard bench for nn_mem_arbiter (MAX_BURST=4); covers NN_ARB_FIXED_PRIO_EN when defined.
module tb_nn_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nn_mem_arbiter_if #(.ADDR_LEN(20), .DATA_LEN(1), .SEL_LEN(2)) bus ();

  nn_mem_arbiter #(
    .ADDR_LEN (20),
    .DATA_LEN (1),
    .SEL_LEN  (2),
    .MAX_BURST(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory model: 1-cycle latency, data = parity of the address
  always @(posedge clk) bus.mem_rdata <= ^bus.mem_addr;

  typedef struct {
    int          id;
    logic        g0, g1, rv0, rv1, mwe, md;
    logic [19:0] ma;
    logic [1:0]  ms;
    logic        rd_chk, rd_exp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_id   = 0;
  logic prev_par = 1'b0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt0",      e.id, 32'(bus.gnt0),      32'(e.g0));
      chk("gnt1",      e.id, 32'(bus.gnt1),      32'(e.g1));
      chk("rvalid0",   e.id, 32'(bus.rvalid0),   32'(e.rv0));
      chk("rvalid1",   e.id, 32'(bus.rvalid1),   32'(e.rv1));
      chk("mem_we",    e.id, 32'(bus.mem_we),    32'(e.mwe));
      chk("mem_addr",  e.id, 32'(bus.mem_addr),  32'(e.ma));
      chk("mem_sel",   e.id, 32'(bus.mem_sel),   32'(e.ms));
      chk("mem_wdata", e.id, 32'(bus.mem_wdata), 32'(e.md));
      if (e.rd_chk) chk("rdata", e.id, 32'(bus.rdata), 32'(e.rd_exp));
    end else if (bus.gnt0 || bus.gnt1 || bus.rvalid0 || bus.rvalid1) begin
      chk("unexpected_activity", cyc_id, 32'(1), 32'(0));
    end
  end

  task automatic step(
    input logic rs, r0, w0, r1, w1,
    input logic [19:0] a1, input logic [1:0] s1,
    input logic eg0, eg1, erv0, erv1, emwe,
    input logic [19:0] ema, input logic [1:0] ems, input logic emd
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst      = rs;
    bus.req0 = r0;
    bus.we0  = w0;
    bus.req1 = r1;
    bus.we1  = w1;
    bus.addr1 = a1;
    bus.sel1  = s1;
    cyc_id++;
    e.id  = cyc_id;
    e.g0  = eg0;  e.g1  = eg1;
    e.rv0 = erv0; e.rv1 = erv1;
    e.mwe = emwe; e.ma  = ema;
    e.ms  = ems;  e.md  = emd;
    e.rd_chk = erv0 | erv1;
    e.rd_exp = prev_par;
    prev_par = ^ema;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc_id);
    $fatal(1);
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = 20'd3; bus.sel0 = 2'd2; bus.wdata0 = 1'b1;
    bus.addr1 = 20'd5; bus.sel1 = 2'd1; bus.wdata1 = 1'b0;

    // reset state, then port-1 read burst at addr 5
    step(1,0,0,0,0, 5,1,  0,0,0,0,0, 0,0,0);
    step(0,0,0,1,0, 5,1,  0,0,0,0,0, 0,0,0);
    step(0,0,0,1,0, 5,1,  0,1,0,0,0, 5,1,0);
    step(0,0,0,1,0, 5,1,  0,1,0,1,0, 5,1,0);
    step(0,0,0,1,0, 5,1,  0,1,0,1,0, 5,1,0);
    step(0,0,0,0,0, 5,1,  0,1,0,1,0, 5,1,0);
    step(0,0,0,0,0, 5,1,  0,0,0,0,0, 0,0,0);

`ifdef NN_ARB_FIXED_PRIO_EN
    step(1,0,0,0,0, 7,3,  0,0,0,0,0, 0,0,0);
    step(0,1,1,1,0, 7,3,  0,0,0,0,0, 0,0,0);
    for (int i = 0; i < 50; i++)
      step(0,1,1,1,0, 7,3,  1,0,0,0,1, 3,2,1);
    step(0,0,1,1,0, 7,3,  1,0,0,0,0, 3,2,1);
    step(0,0,1,1,0, 7,3,  0,1,0,0,0, 7,3,0);
    step(0,0,0,0,0, 7,3,  0,1,0,1,0, 7,3,0);
    step(0,0,0,0,0, 7,3,  0,0,0,0,0, 0,0,0);
`else
    // both request from IDLE after reset: 4 writes on port 0, then reads on port 1
    step(1,0,0,0,0, 7,3,  0,0,0,0,0, 0,0,0);
    step(0,1,1,1,0, 7,3,  0,0,0,0,0, 0,0,0);
    for (int i = 0; i < 4; i++)
      step(0,1,1,1,0, 7,3,  1,0,0,0,1, 3,2,1);
    step(0,1,1,1,0, 7,3,  0,1,0,0,0, 7,3,0);
    for (int i = 0; i < 3; i++)
      step(0,1,1,1,0, 7,3,  0,1,0,1,0, 7,3,0);
    // port 0 drops while owning; then port 1 drops (write) while port 0 waits
    step(0,0,1,1,0, 7,3,  1,0,0,1,0, 3,2,1);
    step(0,1,1,0,1, 7,3,  0,1,0,0,0, 7,3,0);
    // port 0 alone: unlimited ownership
    for (int i = 0; i < 40; i++)
      step(0,1,1,0,0, 7,3,  1,0,0,0,1, 3,2,1);
    step(0,0,1,0,0, 9,1,  1,0,0,0,0, 3,2,1);
    // rr_ptr now points at port 1
    step(0,1,1,1,0, 9,1,  0,0,0,0,0, 0,0,0);
    step(0,0,1,1,0, 9,1,  0,1,0,0,0, 9,1,0);
    // reset mid-burst: read in reset cycle yields no rvalid, rr_ptr back to 0
    step(1,0,1,1,0, 9,1,  0,1,0,1,0, 9,1,0);
    step(0,1,1,1,0, 9,1,  0,0,0,0,0, 0,0,0);
    step(0,1,1,1,0, 9,1,  1,0,0,0,1, 3,2,1);
    step(0,0,1,0,0, 9,1,  1,0,0,0,0, 3,2,1);
    step(0,0,0,0,0, 9,1,  0,0,0,0,0, 0,0,0);
`endif

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
